// File: rtl/alu_decode_stage_if.sv
// ID->EX handshake bundle: instruction side (in_*) and decoded-entry side (out_*).
// The stage takes the slave view; whoever drives instructions and consumes entries takes master.
interface alu_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_alu_ctrl;
  logic            out_use_imm;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_is_load;
  logic            out_is_store;
  logic            out_is_branch;
  logic            out_branch_ne;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_alu_ctrl, out_use_imm, out_imm,
           out_rs1, out_rs2, out_rd, out_reg_write, out_is_load,
           out_is_store, out_is_branch, out_branch_ne, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_alu_ctrl, out_use_imm, out_imm,
           out_rs1, out_rs2, out_rd, out_reg_write, out_is_load,
           out_is_store, out_is_branch, out_branch_ne, out_illegal, out_pc
  );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I ID->EX stage: decodes ALU control/operand selects and registers them
// through a 2-entry skid buffer (main + skid) with backpressure and flush.
module alu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  alu_decode_stage_if.slave  io
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  typedef struct packed {
    logic [3:0]      alu_ctrl;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            branch_ne;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e state_q, state_d;
  dec_t   main_q, main_d;
  dec_t   skid_q, skid_d;
  dec_t   dec;

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        push, pop;

  assign instr = io.in_instr;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  always_comb begin
    dec           = '0;
    dec.alu_ctrl  = ALU_ADD;
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    dec.rd        = instr[11:7];
    dec.pc        = io.in_pc;
    case (opc)
      OP_R: begin
        dec.reg_write = 1'b1;
        if (f3 == 3'b000 && f7 == 7'b0100000) dec.alu_ctrl = ALU_SUB;
        else if (f7 != 7'b0000000)            dec.illegal  = 1'b1;
        else begin
          case (f3)
            3'b000:  dec.alu_ctrl = ALU_ADD;
            3'b111:  dec.alu_ctrl = ALU_AND;
            3'b110:  dec.alu_ctrl = ALU_OR;
            3'b011:  dec.alu_ctrl = ALU_SLTU;
            default: dec.illegal  = 1'b1;
          endcase
        end
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = {{(XLEN-12){instr[31]}}, instr[31:20]};
        case (f3)
          3'b000:  dec.alu_ctrl = ALU_ADD;
          3'b111:  dec.alu_ctrl = ALU_AND;
          3'b110:  dec.alu_ctrl = ALU_OR;
          3'b011:  dec.alu_ctrl = ALU_SLTU;
          default: dec.illegal  = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.is_load   = 1'b1;
        dec.imm       = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        dec.use_imm  = 1'b1;
        dec.is_store = 1'b1;
        dec.imm      = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        // EX compares via the ALU zero flag, so both BEQ and BNE subtract
        dec.alu_ctrl  = ALU_SUB;
        dec.is_branch = 1'b1;
        dec.imm       = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        case (f3)
          3'b000:  dec.branch_ne = 1'b0;
          3'b001:  dec.branch_ne = 1'b1;
          default: dec.illegal   = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal encodings are neutralised so EX never acts on them.
    if (dec.illegal) begin
      dec.alu_ctrl  = ALU_ADD;
      dec.use_imm   = 1'b0;
      dec.imm       = '0;
      dec.reg_write = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
      dec.is_branch = 1'b0;
      dec.branch_ne = 1'b0;
    end
  end

  assign io.in_ready  = (state_q != TWO);
  assign io.out_valid = (state_q != EMPTY);
  assign push = io.in_valid & io.in_ready;
  assign pop  = io.out_valid & io.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          main_d  = dec;
        end
        ONE: begin
          if (push && !pop) begin
            state_d = TWO;
            skid_d  = dec;
          end else if (push && pop) begin
            main_d  = dec;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign io.out_alu_ctrl  = main_q.alu_ctrl;
  assign io.out_use_imm   = main_q.use_imm;
  assign io.out_imm       = main_q.imm;
  assign io.out_rs1       = main_q.rs1;
  assign io.out_rs2       = main_q.rs2;
  assign io.out_rd        = main_q.rd;
  assign io.out_reg_write = main_q.reg_write;
  assign io.out_is_load   = main_q.is_load;
  assign io.out_is_store  = main_q.is_store;
  assign io.out_is_branch = main_q.is_branch;
  assign io.out_branch_ne = main_q.branch_ne;
  assign io.out_illegal   = main_q.illegal;
  assign io.out_pc        = main_q.pc;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: mnemonic-level decode model plus a FIFO of
// expected entries (depth 2), checked every cycle, with directed literal cases.
module tb_alu_decode_stage;
  typedef struct packed {
    logic [3:0]  ctrl;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        ld;
    logic        st;
    logic        br;
    logic        bne;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t dut_e;

  alu_decode_stage_if #(.XLEN(32)) io();
  alu_decode_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .flush(flush), .io(io));

  always #5 clk = ~clk;

  assign dut_e = {io.out_alu_ctrl, io.out_use_imm, io.out_imm, io.out_rs1, io.out_rs2,
                  io.out_rd, io.out_reg_write, io.out_is_load, io.out_is_store,
                  io.out_is_branch, io.out_branch_ne, io.out_illegal, io.out_pc};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Decode by naming the instruction first, then reading its table row.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t  e;
    string m;
    logic [31:0] i_imm, s_imm, b_imm;
    m     = "ILL";
    i_imm = 32'($signed(w) >>> 20);
    s_imm = (i_imm & ~32'h1F) | 32'(w[11:7]);
    b_imm = (32'($signed(w) >>> 19) & 32'hFFFF_F000) | (32'(w[7]) << 11)
          | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    if (w[6:0] == 7'h33 && w[31:25] == 7'h00)
      case (w[14:12]) 3'd0: m = "ADD"; 3'd7: m = "AND"; 3'd6: m = "OR"; 3'd3: m = "SLTU"; default: ; endcase
    if (w[6:0] == 7'h33 && w[31:25] == 7'h20 && w[14:12] == 3'd0) m = "SUB";
    if (w[6:0] == 7'h13)
      case (w[14:12]) 3'd0: m = "ADDI"; 3'd7: m = "ANDI"; 3'd6: m = "ORI"; 3'd3: m = "SLTIU"; default: ; endcase
    if (w[6:0] == 7'h03) m = "LOAD";
    if (w[6:0] == 7'h23) m = "STORE";
    if (w[6:0] == 7'h63 && w[14:12] == 3'd0) m = "BEQ";
    if (w[6:0] == 7'h63 && w[14:12] == 3'd1) m = "BNE";
    e = '0;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.pc = pc;
    e.ctrl = 4'b0010;
    case (m)
      "ADD":   e.rw = 1;
      "SUB":   begin e.rw = 1; e.ctrl = 4'b0100; end
      "AND":   begin e.rw = 1; e.ctrl = 4'b0000; end
      "OR":    begin e.rw = 1; e.ctrl = 4'b0001; end
      "SLTU":  begin e.rw = 1; e.ctrl = 4'b1000; end
      "ADDI":  begin e.rw = 1; e.use_imm = 1; e.imm = i_imm; end
      "ANDI":  begin e.rw = 1; e.use_imm = 1; e.imm = i_imm; e.ctrl = 4'b0000; end
      "ORI":   begin e.rw = 1; e.use_imm = 1; e.imm = i_imm; e.ctrl = 4'b0001; end
      "SLTIU": begin e.rw = 1; e.use_imm = 1; e.imm = i_imm; e.ctrl = 4'b1000; end
      "LOAD":  begin e.rw = 1; e.use_imm = 1; e.imm = i_imm; e.ld = 1; end
      "STORE": begin e.use_imm = 1; e.imm = s_imm; e.st = 1; end
      "BEQ":   begin e.ctrl = 4'b0100; e.imm = b_imm; e.br = 1; end
      "BNE":   begin e.ctrl = 4'b0100; e.imm = b_imm; e.br = 1; e.bne = 1; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  // Expected-entry FIFO: capacity 2, pop before push in the same cycle.
  always @(posedge clk or posedge rst) begin
    if (rst || flush) q.delete();
    else if (io.in_valid && q.size() < 2) begin
      if (q.size() != 0 && io.out_ready) void'(q.pop_front());
      q.push_back(model(io.in_instr, io.in_pc));
    end else if (q.size() != 0 && io.out_ready) void'(q.pop_front());
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", io.out_valid, 1'b0);
      chk("rst_in_ready", io.in_ready, 1'b1);
      chk("rst_fields", dut_e, '0);
    end else begin
      chk("in_ready", io.in_ready, q.size() < 2);
      chk("out_valid", io.out_valid, q.size() != 0);
      if (q.size() != 0) chk("entry", dut_e, q[0]);
    end
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc, input logic rdy);
    io.in_valid = v; io.in_instr = w; io.in_pc = pc; io.out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0, 6: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      default: ;
    endcase
    if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 3) != 0) w[31] = 1'b1;
    return w;
  endfunction

  initial begin
    drive(0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Decode literals, streaming with out_ready=1.
    step(); drive(1, 32'h002081B3, 32'h1000, 1);
    step(); drive(1, 32'h402081B3, 32'h1004, 1);
    @(negedge clk);
    chk("add_valid", io.out_valid, 1'b1);
    chk("add_ctrl", io.out_alu_ctrl, 4'b0010);
    chk("add_regs", {io.out_rs1, io.out_rs2, io.out_rd}, {5'd1, 5'd2, 5'd3});
    chk("add_rw_imm", {io.out_reg_write, io.out_use_imm}, 2'b10);
    step(); drive(1, 32'hFFF00293, 32'h1008, 1);
    @(negedge clk);
    chk("sub_ctrl", io.out_alu_ctrl, 4'b0100);
    step(); drive(1, 32'h00209463, 32'h100C, 1);
    @(negedge clk);
    chk("addi_ctrl", io.out_alu_ctrl, 4'b0010);
    chk("addi_imm", {io.out_use_imm, io.out_imm}, {1'b1, 32'hFFFFFFFF});
    chk("addi_rd", io.out_rd, 5'd5);
    step(); drive(1, 32'h0020C1B3, 32'h1010, 1);
    @(negedge clk);
    chk("bne_ctrl", io.out_alu_ctrl, 4'b0100);
    chk("bne_flags", {io.out_is_branch, io.out_branch_ne, io.out_reg_write}, 3'b110);
    chk("bne_imm", io.out_imm, 32'h00000008);
    step(); drive(0, 32'h0, 32'h0, 1);
    @(negedge clk);
    chk("xor_illegal", {io.out_illegal, io.out_alu_ctrl, io.out_reg_write}, {1'b1, 4'b0010, 1'b0});

    // Backpressure: A and B fill the buffer, then drain in order.
    step(); drive(1, 32'h002081B3, 32'h100, 0);
    step(); drive(1, 32'h402081B3, 32'h104, 0);
    step(); drive(0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("bp_full_ready", io.in_ready, 1'b0);
    chk("bp_hold_pc", io.out_pc, 32'h100);
    step(); drive(0, 32'h0, 32'h0, 1);
    @(negedge clk);
    chk("bp_a_pc", io.out_pc, 32'h100);
    step();
    @(negedge clk);
    chk("bp_b_pc", {io.out_valid, io.out_pc}, {1'b1, 32'h104});
    chk("bp_ready_back", io.in_ready, 1'b1);
    step();
    @(negedge clk);
    chk("bp_drained", io.out_valid, 1'b0);

    // Flush while full, with a concurrent valid input that must be dropped.
    step(); drive(1, 32'h00A00093, 32'h200, 0);
    step(); drive(1, 32'h00B00113, 32'h204, 0);
    step(); drive(1, 32'h00C00193, 32'h208, 1); flush = 1'b1;
    step(); drive(0, 32'h0, 32'h0, 1); flush = 1'b0;
    @(negedge clk);
    chk("flush_empty", {io.out_valid, io.in_ready}, 2'b01);
    step();
    @(negedge clk);
    chk("flush_nothing", io.out_valid, 1'b0);

    // Asynchronous reset mid-cycle while holding one entry.
    step(); drive(1, 32'h402081B3, 32'h300, 0);
    step(); drive(0, 32'h0, 32'h0, 0);
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("arst_out_valid", io.out_valid, 1'b0);
    chk("arst_fields", {io.out_alu_ctrl, io.out_rd, io.out_pc, io.out_reg_write}, '0);
    chk("arst_in_ready", io.in_ready, 1'b1);
    @(negedge clk); #2 rst = 1'b0;
    step(); drive(1, 32'h002081B3, 32'h400, 1);
    step(); drive(0, 32'h0, 32'h0, 1);
    @(negedge clk);
    chk("post_rst_add", {io.out_valid, io.out_alu_ctrl, io.out_rd, io.out_pc},
        {1'b1, 4'b0010, 5'd3, 32'h400});

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 39) == 0);
    end
    step(); drive(0, 32'h0, 32'h0, 1); flush = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("final_empty", io.out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
